// File: rtl/matrix_operand_loader_if.sv
// Command/element handshake and operand bus between the byte-serial source and the loader.
// master = upstream driver side, slave = loader side.
interface matrix_operand_loader_if #(
    parameter int N      = 5,
    parameter int ELEM_W = 8
);
    localparam int BUS_W = N * N * ELEM_W;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [7:0]        cmd_scalar;
    logic [ELEM_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op_code;
    logic [BUS_W-1:0]  matrix_a;
    logic [BUS_W-1:0]  matrix_b;
    logic [7:0]        scalar;
    logic              start;
    logic              operands_valid;
    logic              busy;
    logic              cmd_error;

    modport master (
        output cmd_valid, cmd_op, cmd_scalar, in_data, in_valid,
        input  cmd_ready, in_ready, op_code, matrix_a, matrix_b, scalar,
               start, operands_valid, busy, cmd_error
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_scalar, in_data, in_valid,
        output cmd_ready, in_ready, op_code, matrix_a, matrix_b, scalar,
               start, operands_valid, busy, cmd_error
    );
endinterface

// File: rtl/matrix_operand_loader.sv
// Byte-serial operand loader: takes a command, streams A (and B for add/sub) into packed
// operand buses, then pulses start and holds the operands stable for the coprocessor.
module matrix_operand_loader #(
    parameter int N      = 5,
    parameter int ELEM_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    matrix_operand_loader_if.slave bus
);
    localparam int unsigned NE    = N * N;
    localparam int unsigned BUS_W = NE * ELEM_W;
    localparam int unsigned CNT_W = (NE > 1) ? $clog2(NE) : 1;

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, ISSUE} state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic [7:0]        scalar_q;
    logic [BUS_W-1:0]  a_q;
    logic [BUS_W-1:0]  b_q;
    logic              ov_q;
    logic              err_q;

    logic              cmd_hs;
    logic              cmd_legal;
    logic              elem_hs;
    logic              last_elem;
    logic              needs_b;
    logic              cmd_ready_c;
    logic              in_ready_c;
    logic              start_c;
    logic              busy_c;

    assign cmd_legal = (bus.cmd_op <= 3'b101);
    assign cmd_hs    = bus.cmd_valid && cmd_ready_c;
    assign elem_hs   = bus.in_valid && in_ready_c;
    assign last_elem = (cnt == CNT_W'(NE - 1));
    assign needs_b   = (op_q == 3'b000) || (op_q == 3'b001);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        cmd_ready_c = 1'b0;
        in_ready_c  = 1'b0;
        start_c     = 1'b0;
        busy_c      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready_c = 1'b1;
                busy_c      = 1'b0;
                if (bus.cmd_valid && cmd_legal) begin
                    state_next = LOAD_A;
                end
            end
            LOAD_A: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && last_elem) begin
                    state_next = needs_b ? LOAD_B : ISSUE;
                end
            end
            LOAD_B: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && last_elem) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                start_c    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Rejected opcodes only raise cmd_error; previously loaded operands stay valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            op_q     <= '0;
            scalar_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ov_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (cmd_hs) begin
                if (cmd_legal) begin
                    op_q     <= bus.cmd_op;
                    scalar_q <= bus.cmd_scalar;
                    a_q      <= '0;
                    b_q      <= '0;
                    cnt      <= '0;
                    ov_q     <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (elem_hs) begin
                if (state == LOAD_A) begin
                    a_q[ELEM_W*int'(cnt) +: ELEM_W] <= bus.in_data;
                end else begin
                    b_q[ELEM_W*int'(cnt) +: ELEM_W] <= bus.in_data;
                end
                cnt <= last_elem ? '0 : cnt + CNT_W'(1);
            end
            if (state == ISSUE) begin
                ov_q <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready      = cmd_ready_c;
    assign bus.in_ready       = in_ready_c;
    assign bus.start          = start_c;
    assign bus.busy           = busy_c;
    assign bus.op_code        = op_q;
    assign bus.scalar         = scalar_q;
    assign bus.matrix_a       = a_q;
    assign bus.matrix_b       = b_q;
    assign bus.operands_valid = ov_q;
    assign bus.cmd_error      = err_q;
endmodule
